// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounces per-floor call buttons, latches presses as
// pending calls, offers them one at a time to the car controller over a
// valid/ready handshake in round-robin order, and clears them on arrival.
module elevator_call_panel #(
  parameter int NUM_FLOORS      = 8,
  parameter int FLOOR_W         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [FLOOR_W-1:0]    req_floor,
  input  logic                  arrive_valid,
  input  logic [FLOOR_W-1:0]    arrive_floor,
  output logic [NUM_FLOORS-1:0] call_lamp,
  output logic [CNT_W-1:0]      pending_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]    DB_PRE     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] LAST_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [DB_W-1:0]         db_cnt [NUM_FLOORS];
  logic [NUM_FLOORS-1:0]   debounced;
  logic [NUM_FLOORS-1:0]   db_rise;
  logic [NUM_FLOORS-1:0]   pending, pending_nxt;
  logic [NUM_FLOORS-1:0]   issued, issued_nxt;
  logic [NUM_FLOORS-1:0]   arr_mask, hs_mask, cand, cand_rot;
  logic [NUM_FLOORS-1:0]   lamp_nxt;
  logic [2*NUM_FLOORS-1:0] cand_dbl;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [FLOOR_W-1:0]      rr_ptr, rr_nxt;
  logic [FLOOR_W-1:0]      req_floor_nxt, sel_floor;
  logic                    found, handshake, arr_hit, offer_hit;
  int                      sel_idx;

  // Debounce: count consecutive high samples; a low sample restarts the count.
  // NOTE: the counter array is control state, so every entry is reset
  // explicitly rather than left to power-up values like a data memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FLOORS; i++) db_cnt[i] <= '0;
      debounced <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (!btn[i]) begin
          db_cnt[i]    <= '0;
          debounced[i] <= 1'b0;
        end else begin
          if (db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + 1'b1;
          if (db_cnt[i] == DB_PRE) debounced[i] <= 1'b1;
        end
      end
    end
  end

  // Press detect: the debounced level rises on this edge.
  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++)
      db_rise[i] = btn[i] & ~debounced[i] & (db_cnt[i] == DB_PRE);
  end

  // Decode arrival and handshake into one-hot floor masks.
  always_comb begin
    arr_hit   = arrive_valid && (arrive_floor <= LAST_FLOOR);
    offer_hit = arr_hit && (arrive_floor == req_floor);
    arr_mask  = '0;
    hs_mask   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (arr_hit && (arrive_floor == FLOOR_W'(i))) arr_mask[i] = 1'b1;
      if (handshake && (req_floor == FLOOR_W'(i)))  hs_mask[i]  = 1'b1;
    end
  end

  // Round-robin pick: rotate candidates so rr_ptr lands at bit 0, take the
  // lowest set bit. Floors being cleared by an arrival this edge are skipped.
  always_comb begin
    cand      = pending & ~issued & ~arr_mask;
    cand_dbl  = {cand, cand} >> rr_ptr;
    cand_rot  = cand_dbl[NUM_FLOORS-1:0];
    found     = 1'b0;
    sel_floor = '0;
    sel_idx   = 0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (!found && cand_rot[i]) begin
        found   = 1'b1;
        sel_idx = int'(rr_ptr) + i;
        if (sel_idx >= NUM_FLOORS) sel_idx = sel_idx - NUM_FLOORS;
        sel_floor = FLOOR_W'(sel_idx);
      end
    end
  end

  // Offer FSM next-state: IDLE picks a call, OFFER holds until handshake or
  // until the car arrives at the offered floor (withdrawal).
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    req_floor_nxt = req_floor;
    rr_nxt        = rr_ptr;
    handshake     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = OFFER;
          req_floor_nxt = sel_floor;
        end
      end
      OFFER: begin
        if (req_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
          rr_nxt    = (req_floor == LAST_FLOOR) ? '0 : req_floor + 1'b1;
        end else if (offer_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Call bookkeeping: press sets pending, handshake moves pending to issued,
  // arrival clears both last so it wins over either.
  always_comb begin
    pending_nxt = (pending | (db_rise & ~issued)) & ~hs_mask;
    issued_nxt  = issued | hs_mask;
    pending_nxt = pending_nxt & ~arr_mask;
    issued_nxt  = issued_nxt & ~arr_mask;
    lamp_nxt    = pending_nxt | issued_nxt;
    cnt_nxt     = '0;
    for (int i = 0; i < NUM_FLOORS; i++) cnt_nxt = cnt_nxt + CNT_W'(lamp_nxt[i]);
  end

  // State registers; lamps and count track the call state of the same edge.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_floor   <= '0;
      rr_ptr      <= '0;
      pending     <= '0;
      issued      <= '0;
      call_lamp   <= '0;
      pending_cnt <= '0;
    end else begin
      state       <= state_nxt;
      req_floor   <= req_floor_nxt;
      rr_ptr      <= rr_nxt;
      pending     <= pending_nxt;
      issued      <= issued_nxt;
      call_lamp   <= lamp_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  assign req_valid = (state == OFFER);

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with default parameters.
module tb_elevator_call_panel;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_floor;
  logic       arrive_valid;
  logic [3:0] arrive_floor;
  logic [7:0] call_lamp;
  logic [3:0] pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count;
  logic [3:0] hs_floor;
  logic saw_valid, saw_lamp;

  elevator_call_panel #(
    .NUM_FLOORS(8), .FLOOR_W(4), .DEBOUNCE_CYCLES(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .req_valid(req_valid), .req_ready(req_ready), .req_floor(req_floor),
    .arrive_valid(arrive_valid), .arrive_floor(arrive_floor),
    .call_lamp(call_lamp), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; btn = '0; req_ready = 1'b0;
    arrive_valid = 1'b0; arrive_floor = '0;
    #2;
    check("rst_valid", req_valid, 0);
    check("rst_floor", req_floor, 0);
    check("rst_lamp", call_lamp, 0);
    check("rst_cnt", pending_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_valid", req_valid, 0);

    // Single press on floor 5, full lifecycle
    req_ready = 1'b1;
    btn = 8'h20;
    step(); step(); step();
    check("f5_deb3_lamp", call_lamp, 8'h00);
    step();
    check("f5_lamp", call_lamp, 8'h20);
    check("f5_cnt", pending_cnt, 1);
    check("f5_valid_not_yet", req_valid, 0);
    btn = 8'h00;
    step();
    check("f5_valid", req_valid, 1);
    check("f5_floor", req_floor, 5);
    step();
    check("f5_hs_valid", req_valid, 0);
    check("f5_issued_lamp", call_lamp, 8'h20);
    check("f5_issued_cnt", pending_cnt, 1);
    step(); step(); step();
    check("f5_no_reoffer", req_valid, 0);
    arrive_valid = 1'b1; arrive_floor = 4'd5;
    step();
    arrive_valid = 1'b0;
    check("f5_arr_lamp", call_lamp, 8'h00);
    check("f5_arr_cnt", pending_cnt, 0);

    // Glitchy button on floor 2 never reaches the debounce threshold
    saw_valid = 1'b0; saw_lamp = 1'b0;
    for (int i = 0; i < 11; i++) begin
      btn = (i == 3 || i >= 7) ? 8'h00 : 8'h04;
      step();
      if (req_valid) saw_valid = 1'b1;
      if (call_lamp != 8'h00) saw_lamp = 1'b1;
    end
    check("glitch_valid", saw_valid, 0);
    check("glitch_lamp", saw_lamp, 0);

    // Held button on floor 2 registers exactly once
    hs_count = 0; hs_floor = '0;
    btn = 8'h04;
    for (int i = 0; i < 20; i++) begin
      if (req_valid && req_ready) begin
        hs_count++;
        hs_floor = req_floor;
      end
      step();
    end
    btn = 8'h00;
    step();
    check("held_hs_count", hs_count, 1);
    check("held_hs_floor", hs_floor, 2);
    check("held_lamp", call_lamp, 8'h04);
    arrive_valid = 1'b1; arrive_floor = 4'd2;
    step();
    arrive_valid = 1'b0;
    check("held_arr_lamp", call_lamp, 8'h00);

    // Move rr_ptr to 4 via a handshake on floor 3
    btn = 8'h08;
    step(); step(); step(); step();
    btn = 8'h00;
    step();
    check("rr_setup_floor", req_floor, 3);
    step();
    check("rr_setup_hs", req_valid, 0);
    arrive_valid = 1'b1; arrive_floor = 4'd3;
    step();
    arrive_valid = 1'b0;
    check("rr_setup_clear", call_lamp, 8'h00);

    // Floors 1,3,6 pending with rr_ptr=4 -> offers 6, 1, 3
    req_ready = 1'b0;
    btn = 8'h4A;
    step(); step(); step(); step();
    btn = 8'h00;
    check("rr_lamp", call_lamp, 8'h4A);
    check("rr_cnt", pending_cnt, 3);
    step();
    check("rr_first_valid", req_valid, 1);
    check("rr_first_floor", req_floor, 6);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_hold_valid", req_valid, 1);
      check("rr_hold_floor", req_floor, 6);
    end
    req_ready = 1'b1;
    step();
    check("rr_gap1", req_valid, 0);
    step();
    check("rr_second_valid", req_valid, 1);
    check("rr_second_floor", req_floor, 1);
    step();
    check("rr_gap2", req_valid, 0);
    step();
    check("rr_third_valid", req_valid, 1);
    check("rr_third_floor", req_floor, 3);
    step();
    check("rr_gap3", req_valid, 0);
    check("rr_issued_lamp", call_lamp, 8'h4A);
    req_ready = 1'b0;
    arrive_valid = 1'b1; arrive_floor = 4'd1;
    step();
    arrive_floor = 4'd3;
    step();
    arrive_floor = 4'd6;
    step();
    arrive_valid = 1'b0;
    check("rr_clear_lamp", call_lamp, 8'h00);
    check("rr_clear_cnt", pending_cnt, 0);

    // Withdrawal: offering floor 3, floor 7 pending, car arrives at 3
    btn = 8'h08;
    step(); step(); step(); step();
    btn = 8'h00;
    step();
    check("wd_offer_floor", req_floor, 3);
    btn = 8'h80;
    step(); step(); step(); step();
    btn = 8'h00;
    check("wd_other_press_valid", req_valid, 1);
    check("wd_other_press_floor", req_floor, 3);
    check("wd_lamp", call_lamp, 8'h88);
    check("wd_cnt", pending_cnt, 2);
    arrive_valid = 1'b1; arrive_floor = 4'd3;
    step();
    arrive_valid = 1'b0;
    check("wd_valid", req_valid, 0);
    check("wd_lamp_after", call_lamp, 8'h80);
    check("wd_cnt_after", pending_cnt, 1);
    step();
    check("wd_next_valid", req_valid, 1);
    check("wd_next_floor", req_floor, 7);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check("wd_hs_valid", req_valid, 0);
    check("wd_hs_lamp", call_lamp, 8'h80);

    // Handshake and arrival on floor 4 on the same edge
    btn = 8'h10;
    step(); step(); step(); step();
    btn = 8'h00;
    step();
    check("same_offer_floor", req_floor, 4);
    req_ready = 1'b1;
    arrive_valid = 1'b1; arrive_floor = 4'd4;
    step();
    req_ready = 1'b0;
    arrive_valid = 1'b0;
    check("same_valid", req_valid, 0);
    check("same_lamp", call_lamp, 8'h80);
    check("same_cnt", pending_cnt, 1);
    step(); step(); step();
    check("same_no_reoffer", req_valid, 0);

    // Out-of-range arrivals are ignored
    arrive_valid = 1'b1; arrive_floor = 4'd12;
    step();
    arrive_floor = 4'd15;
    step();
    arrive_valid = 1'b0;
    check("oor_lamp", call_lamp, 8'h80);
    check("oor_cnt", pending_cnt, 1);
    check("oor_valid", req_valid, 0);

    // rr_ptr advanced to 5 by the same-edge handshake: floors 2,6 -> 6 first
    btn = 8'h44;
    step(); step(); step(); step();
    btn = 8'h00;
    step();
    check("rr5_first", req_floor, 6);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check("rr5_gap", req_valid, 0);
    step();
    check("rr5_second_valid", req_valid, 1);
    check("rr5_second_floor", req_floor, 2);
    step();
    check("rr5_hold_floor", req_floor, 2);

    // Asynchronous reset while offering
    rst_n = 1'b0;
    #1;
    check("arst_valid", req_valid, 0);
    check("arst_floor", req_floor, 0);
    check("arst_lamp", call_lamp, 8'h00);
    check("arst_cnt", pending_cnt, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("arst_idle_valid", req_valid, 0);
    check("arst_idle_lamp", call_lamp, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
Request-producer end of the elevator floor-request interface. Debounces per-floor call buttons and latches each press as a pending call. Issues calls one at a time to the elevator controller over a valid/ready handshake, using round-robin order. Clears a call when the controller reports the car has arrived at that floor, and drives the per-floor call lamps.

Parameters:
NUM_FLOORS, 8, number of floors / buttons (2..15)
FLOOR_W, 4, width of floor index buses
DEBOUNCE_CYCLES, 4, consecutive high samples required to accept a press (>=1)
CNT_W, 4, width of pending_cnt (must hold NUM_FLOORS)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  NUM_FLOORS  raw call buttons, bit i = floor i, active high
req_valid  output  1  call offer valid
req_ready  input  1  controller accepts offered call
req_floor  output  FLOOR_W  floor of offered call
arrive_valid  input  1  one-cycle pulse: car stopped at arrive_floor
arrive_floor  input  FLOOR_W  floor where car stopped
call_lamp  output  NUM_FLOORS  lamp i lit while floor i has a pending or issued call
pending_cnt  output  CNT_W  number of lit lamps

Behaviour:
- Reset (async assert, sync release): req_valid=0, req_floor=0, call_lamp=0, pending_cnt=0. All debounce counters, debounced levels, pending and issued bits are 0. FSM is IDLE. rr_ptr=0.
- Debounce, per floor: the counter increments on each edge where btn[i]=1, saturating at DEBOUNCE_CYCLES. A low sample clears the counter and the debounced level. The debounced level rises on the edge where the counter reaches DEBOUNCE_CYCLES.
- Press registration: on the edge where debounced[i] rises, set pending[i], unless pending[i] or issued[i] is already set (then no effect). A held button registers exactly once. A new press needs release and re-debounce.
- Per-floor status: call_lamp[i] = pending[i] | issued[i], registered. pending_cnt = popcount(call_lamp), registered, updated on the same edge as the lamps.
- FSM states: IDLE and OFFER.
  - IDLE: if any floor has pending & ~issued, select one by round-robin: search starts at rr_ptr, ascending, wrapping at NUM_FLOORS-1 -> 0. On the next edge, load req_floor, set req_valid=1, go to OFFER. Otherwise stay in IDLE with req_valid=0.
  - OFFER: req_valid and req_floor stay stable until the handshake (req_valid & req_ready sampled high on the same edge).
  - On handshake: pending[f]=0, issued[f]=1, rr_ptr=(f+1) mod NUM_FLOORS, req_valid=0, go to IDLE. There is always at least one idle cycle between offers.
- Latency: a button held high from edge 1 gives pending at edge DEBOUNCE_CYCLES and req_valid high after edge DEBOUNCE_CYCLES+1 when the FSM is in IDLE.
- Arrival: when arrive_valid=1 and arrive_floor<NUM_FLOORS, clear pending and issued for that floor on that edge. arrive_floor>=NUM_FLOORS is ignored.
- Arrival at the floor currently offered in OFFER: the offer is withdrawn. req_valid=0 next cycle, FSM goes to IDLE, rr_ptr is unchanged. This is the only permitted deassertion of req_valid without a handshake.
- Handshake and arrival for the same floor on the same edge: arrival wins. The floor ends with pending=0 and issued=0, and rr_ptr still advances.
- Press registration and arrival for the same floor on the same edge: arrival wins, and the press is discarded.
- An arrival for a floor other than the offered one does not disturb the offer.
- An issued call stays lit until its arrival. It is never re-offered.

Test Plan:
- Reset with btn=0 -> all outputs 0. Assert rst_n=0 while req_valid=1 in OFFER -> req_valid=0 immediately and FSM returns to IDLE.
- btn[5] high for 4 cycles, req_ready=1 -> call_lamp=0x20 and pending_cnt=1. req_valid=1 with req_floor=5 one cycle later. Handshake leaves lamp 5 lit. arrive_valid with floor 5 -> call_lamp=0, pending_cnt=0.
- btn[2] glitch high for 3 cycles, low, then high for 3 cycles -> no lamp and req_valid never asserts. btn[2] held for 20 cycles -> exactly one handshake for floor 2.
- Floors 1, 3, 6 pending, rr_ptr=4 -> offers in order 6, 1, 3 with one idle cycle between handshakes. req_floor stays stable while req_ready=0 for 5 cycles.
- Offering floor 3 with req_ready=0, then arrive_valid with floor 3 -> req_valid=0 next cycle and lamp 3 off. Pending floor 7 is offered afterwards.
- Same edge: handshake on floor 4 plus arrive_valid floor 4 -> lamp 4 off and not re-offered. arrive_floor=12 -> no state change.
